// File: rtl/external_clk.sv
// Clock/reset sequencer for the SM83 core: derives the nine phase clocks over an
// 8-step machine phase and sequences oscillator enable, stable and core resets.
module external_clk #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESET,
    output logic ADR_CLK_P,
    output logic ADR_CLK_N,
    output logic DATA_CLK_P,
    output logic DATA_CLK_N,
    output logic INC_CLK_P,
    output logic INC_CLK_N,
    output logic LATCH_CLK,
    output logic MAIN_CLK_P,
    output logic MAIN_CLK_N,
    output logic OSC_ENA,
    output logic OSC_STABLE,
    output logic CLK_ENA,
    output logic ASYNC_RESET,
    output logic SYNC_RESET
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);
    localparam int         NUM_PH_OUT = 5;
    localparam int         NUM_PAIRS  = 4;

    // Per-output phase masks: bit n set means the output is high in phase n.
    // Order: 0 ADR, 1 DATA, 2 INC, 3 MAIN, 4 LATCH (LATCH has no complement).
    localparam logic [NUM_PH_OUT-1:0][7:0] PH_MASK = {
        8'h08,  // LATCH: ph 3
        8'h0F,  // MAIN : ph 0..3
        8'h33,  // INC  : ph 0,1,4,5
        8'h3C,  // DATA : ph 2..5
        8'hC3   // ADR  : ph 6,7,0,1
    };

    logic [7:0] cnt_reg, cnt_next;
    logic [2:0] ph_reg, ph_next;
    logic       run_reg, run_next;
    logic       wrapped_reg, wrapped_next;
    logic       osc_ena_reg, osc_ena_next;
    logic       stable_reg, stable_next;
    logic       async_reset_reg;
    logic       sync_reset_reg;

    logic [NUM_PH_OUT-1:0] ph_p_reg;
    logic [NUM_PAIRS-1:0]  ph_n_reg;

    // The counter saturates at STABLE_CYCLES; the edge after that is marked by
    // run, which keeps the counter within 8 bits across the full legal range.
    always_comb begin
        cnt_next     = cnt_reg;
        ph_next      = 3'd0;
        run_next     = run_reg;
        wrapped_next = wrapped_reg;
        osc_ena_next = 1'b1;
        stable_next  = stable_reg;

        if (cnt_reg != STABLE_CNT) begin
            cnt_next = cnt_reg + 8'd1;
        end
        stable_next = stable_reg | (cnt_next == STABLE_CNT);
        run_next    = run_reg | stable_reg;

        if (run_reg) begin
            ph_next      = ph_reg + 3'd1;
            wrapped_next = wrapped_reg | (ph_reg == 3'd7);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_reg         <= 8'd0;
            ph_reg          <= 3'd0;
            run_reg         <= 1'b0;
            wrapped_reg     <= 1'b0;
            osc_ena_reg     <= 1'b0;
            stable_reg      <= 1'b0;
            async_reset_reg <= 1'b1;
            sync_reset_reg  <= 1'b1;
        end else begin
            cnt_reg         <= cnt_next;
            ph_reg          <= ph_next;
            run_reg         <= run_next;
            wrapped_reg     <= wrapped_next;
            osc_ena_reg     <= osc_ena_next;
            stable_reg      <= stable_next;
            async_reset_reg <= ~run_next;
            sync_reset_reg  <= ~wrapped_next;
        end
    end

    // Outputs decode the next phase so that each flop lines up with ph_reg.
    generate
        for (genvar gi = 0; gi < NUM_PH_OUT; gi++) begin : g_ph_p
            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    ph_p_reg[gi] <= 1'b0;
                end else begin
                    ph_p_reg[gi] <= run_next & PH_MASK[gi][ph_next];
                end
            end
        end

        // Complements get their own flops rather than an inverter on the output.
        for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_ph_n
            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    ph_n_reg[gi] <= 1'b1;
                end else begin
                    ph_n_reg[gi] <= ~(run_next & PH_MASK[gi][ph_next]);
                end
            end
        end
    endgenerate

    assign ADR_CLK_P   = ph_p_reg[0];
    assign ADR_CLK_N   = ph_n_reg[0];
    assign DATA_CLK_P  = ph_p_reg[1];
    assign DATA_CLK_N  = ph_n_reg[1];
    assign INC_CLK_P   = ph_p_reg[2];
    assign INC_CLK_N   = ph_n_reg[2];
    assign MAIN_CLK_P  = ph_p_reg[3];
    assign MAIN_CLK_N  = ph_n_reg[3];
    assign LATCH_CLK   = ph_p_reg[4];
    assign OSC_ENA     = osc_ena_reg;
    assign OSC_STABLE  = stable_reg;
    assign CLK_ENA     = stable_reg;
    assign ASYNC_RESET = async_reset_reg;
    assign SYNC_RESET  = sync_reset_reg;

endmodule

// File: tb/tb_external_clk.sv
// Directed bench for external_clk: startup latencies, phase table, complement
// invariant, mid-run and mid-startup resets, and a STABLE_CYCLES=2 instance.
module tb_external_clk;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    logic a_adr_p, a_adr_n, a_data_p, a_data_n, a_inc_p, a_inc_n, a_latch;
    logic a_main_p, a_main_n, a_osc_ena, a_osc_stable, a_clk_ena, a_async, a_sync;
    logic b_adr_p, b_adr_n, b_data_p, b_data_n, b_inc_p, b_inc_n, b_latch;
    logic b_main_p, b_main_n, b_osc_ena, b_osc_stable, b_clk_ena, b_async, b_sync;

    external_clk #(.STABLE_CYCLES(16)) dut_a (
        .CLK(clk), .RESET(rst_a),
        .ADR_CLK_P(a_adr_p), .ADR_CLK_N(a_adr_n),
        .DATA_CLK_P(a_data_p), .DATA_CLK_N(a_data_n),
        .INC_CLK_P(a_inc_p), .INC_CLK_N(a_inc_n),
        .LATCH_CLK(a_latch),
        .MAIN_CLK_P(a_main_p), .MAIN_CLK_N(a_main_n),
        .OSC_ENA(a_osc_ena), .OSC_STABLE(a_osc_stable), .CLK_ENA(a_clk_ena),
        .ASYNC_RESET(a_async), .SYNC_RESET(a_sync)
    );

    external_clk #(.STABLE_CYCLES(2)) dut_b (
        .CLK(clk), .RESET(rst_b),
        .ADR_CLK_P(b_adr_p), .ADR_CLK_N(b_adr_n),
        .DATA_CLK_P(b_data_p), .DATA_CLK_N(b_data_n),
        .INC_CLK_P(b_inc_p), .INC_CLK_N(b_inc_n),
        .LATCH_CLK(b_latch),
        .MAIN_CLK_P(b_main_p), .MAIN_CLK_N(b_main_n),
        .OSC_ENA(b_osc_ena), .OSC_STABLE(b_osc_stable), .CLK_ENA(b_clk_ena),
        .ASYNC_RESET(b_async), .SYNC_RESET(b_sync)
    );

    // Packed view: {ADR_P,ADR_N,DATA_P,DATA_N,INC_P,INC_N,LATCH,MAIN_P,MAIN_N,
    //               OSC_ENA,OSC_STABLE,CLK_ENA,ASYNC_RESET,SYNC_RESET}
    logic [13:0] vec_a, vec_b;
    assign vec_a = {a_adr_p, a_adr_n, a_data_p, a_data_n, a_inc_p, a_inc_n, a_latch,
                    a_main_p, a_main_n, a_osc_ena, a_osc_stable, a_clk_ena, a_async, a_sync};
    assign vec_b = {b_adr_p, b_adr_n, b_data_p, b_data_n, b_inc_p, b_inc_n, b_latch,
                    b_main_p, b_main_n, b_osc_ena, b_osc_stable, b_clk_ena, b_async, b_sync};

    // Hand-written phase table, rows {MAIN,ADR,DATA,INC,LATCH} for ph 0..7.
    logic [4:0] phase_tab [8] = '{5'b11010, 5'b11010, 5'b10100, 5'b10101,
                                  5'b00110, 5'b00110, 5'b01000, 5'b01000};

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected outputs after c consecutive RESET=1 edges (c=0: in reset).
    function automatic logic [13:0] expect_vec(input int s, input int c);
        logic [4:0] row;
        logic       main_p, adr_p, data_p, inc_p, latch;
        row = 5'b00000;
        if (c >= s + 1) row = phase_tab[(c - s - 1) % 8];
        {main_p, adr_p, data_p, inc_p, latch} = row;
        return {adr_p, ~adr_p, data_p, ~data_p, inc_p, ~inc_p, latch,
                main_p, ~main_p, (c >= 1), (c >= s), (c >= s), (c < s + 1), (c < s + 9)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        check_val("cmpl_a", {a_adr_p ^ a_adr_n, a_data_p ^ a_data_n,
                             a_inc_p ^ a_inc_n, a_main_p ^ a_main_n}, 32'hF);
        check_val("cmpl_b", {b_adr_p ^ b_adr_n, b_data_p ^ b_data_n,
                             b_inc_p ^ b_inc_n, b_main_p ^ b_main_n}, 32'hF);
    endtask

    initial begin
        // Power-up: both instances held in reset, outputs must stay static.
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val($sformatf("rst_a_%0d", i), 32'(vec_a), 32'(expect_vec(16, 0)));
            check_val($sformatf("rst_b_%0d", i), 32'(vec_b), 32'(expect_vec(2, 0)));
        end

        // Startup and steady-state phases; ph=5 of machine cycle 4 lands on c=46.
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int c = 1; c <= 46; c++) begin
            tick();
            check_val($sformatf("start_a_c%0d", c), 32'(vec_a), 32'(expect_vec(16, c)));
            if (c <= 30)
                check_val($sformatf("start_b_c%0d", c), 32'(vec_b), 32'(expect_vec(2, c)));
        end

        // One-cycle reset mid-run.
        rst_a = 1'b0;
        tick();
        check_val("midrun_rst", 32'(vec_a), 32'(expect_vec(16, 0)));
        rst_a = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            tick();
            check_val($sformatf("restart_a_c%0d", c), 32'(vec_a), 32'(expect_vec(16, c)));
        end

        // Reset during startup at c=10, before OSC_STABLE.
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check_val($sformatf("pre_a_c%0d", c), 32'(vec_a), 32'(expect_vec(16, c)));
        end
        rst_a = 1'b0;
        tick();
        check_val("startup_rst", 32'(vec_a), 32'(expect_vec(16, 0)));
        rst_a = 1'b1;
        for (int c = 1; c <= 170; c++) begin
            tick();
            check_val($sformatf("resume_a_c%0d", c), 32'(vec_a), 32'(expect_vec(16, c)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
